// File: rtl/param_queue.sv
// param_queue: parametrised synchronous FIFO with optional empty fall-through, almost flags, occupancy, flush and sticky errors
// ports: clk/reset (async, active-high); inEnable/dataIn/inReady push side; outEnable/dataOut/outReady pop side;
// flush clears entries, clearErr clears overflow/underflow; count, almostFull, almostEmpty report occupancy
module param_queue #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int BYPASS    = 1,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inEnable,
  input  logic [WIDTH-1:0]           dataIn,
  output logic                       inReady,
  input  logic                       outEnable,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       outReady,
  input  logic                       flush,
  input  logic                       clearErr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almostFull,
  output logic                       almostEmpty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic BP = BYPASS != 0;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic empty, push, pop, wr, rd;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    empty       = count == '0;
    inReady     = count < CW'(DEPTH);
    outReady    = !empty || (BP && inEnable);
    dataOut     = !empty ? mem[head] : (BP && inEnable) ? dataIn : '0;
    push        = inEnable && inReady;
    pop         = outEnable && outReady;
    // a pop while empty can only be the fall-through, which never touches storage
    wr          = push && !(pop && empty);
    rd          = pop && !empty;
    almostFull  = count >= CW'(AFULL_TH);
    almostEmpty = count <= CW'(AEMPTY_TH);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !clearErr) || (inEnable && !inReady);
      underflow <= (underflow && !clearErr) || (outEnable && !outReady);
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wr) tail <= nxt(tail);
        if (rd) head <= nxt(head);
        count <= count + CW'(wr) - CW'(rd);
      end
    end
  always_ff @(posedge clk)
    if (wr && !flush) mem[tail] <= dataIn;
endmodule

// File: tb/tb_param_queue.sv
// tb_param_queue: drives three param_queue configurations with shared stimulus against queue-based reference models
module tb_param_queue;
  logic clk = 0, reset = 1;
  logic ie = 0, oe = 0, fl = 0, ce = 0;
  logic [15:0] din = '0;
  int n_cmp = 0, n_err = 0;
  int dep [3] = '{32, 32, 5};
  int bp  [3] = '{1, 0, 1};
  int aft [3] = '{28, 28, 4};
  int aet [3] = '{4, 4, 1};
  logic [15:0] q0 [$], q1 [$], q2 [$];
  logic ov [3], un [3];
  logic [15:0] o_data [3];
  logic o_irdy [3], o_ordy [3], o_af [3], o_ae [3], o_ov [3], o_un [3];
  logic [5:0] c0, c1;
  logic [2:0] c2;
  logic [31:0] o_cnt [3];
  assign o_cnt[0] = 32'(c0);
  assign o_cnt[1] = 32'(c1);
  assign o_cnt[2] = 32'(c2);
  always #5 clk = ~clk;

  param_queue u0 (.clk(clk), .reset(reset), .inEnable(ie), .dataIn(din), .inReady(o_irdy[0]),
    .outEnable(oe), .dataOut(o_data[0]), .outReady(o_ordy[0]), .flush(fl), .clearErr(ce), .count(c0),
    .almostFull(o_af[0]), .almostEmpty(o_ae[0]), .overflow(o_ov[0]), .underflow(o_un[0]));
  param_queue #(.BYPASS(0)) u1 (.clk(clk), .reset(reset), .inEnable(ie), .dataIn(din), .inReady(o_irdy[1]),
    .outEnable(oe), .dataOut(o_data[1]), .outReady(o_ordy[1]), .flush(fl), .clearErr(ce), .count(c1),
    .almostFull(o_af[1]), .almostEmpty(o_ae[1]), .overflow(o_ov[1]), .underflow(o_un[1]));
  param_queue #(.DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) u2 (.clk(clk), .reset(reset), .inEnable(ie), .dataIn(din),
    .inReady(o_irdy[2]), .outEnable(oe), .dataOut(o_data[2]), .outReady(o_ordy[2]), .flush(fl), .clearErr(ce),
    .count(c2), .almostFull(o_af[2]), .almostEmpty(o_ae[2]), .overflow(o_ov[2]), .underflow(o_un[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qs(input int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
  endfunction

  function automatic logic [15:0] qh(input int k);
    if (qs(k) == 0) return '0;
    return k == 0 ? q0[0] : k == 1 ? q1[0] : q2[0];
  endfunction

  task automatic clear_models();
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin ov[k] = 0; un[k] = 0; end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int n = qs(k);
      logic byp = (bp[k] != 0) && ie;
      chk($sformatf("inReady%0d", k), 32'(o_irdy[k]), 32'(n < dep[k]));
      chk($sformatf("outReady%0d", k), 32'(o_ordy[k]), 32'(n != 0 || byp));
      chk($sformatf("dataOut%0d", k), 32'(o_data[k]), 32'(n != 0 ? qh(k) : byp ? din : 16'h0));
      chk($sformatf("count%0d", k), o_cnt[k], 32'(n));
      chk($sformatf("almostFull%0d", k), 32'(o_af[k]), 32'(n >= aft[k]));
      chk($sformatf("almostEmpty%0d", k), 32'(o_ae[k]), 32'(n <= aet[k]));
      chk($sformatf("overflow%0d", k), 32'(o_ov[k]), 32'(ov[k]));
      chk($sformatf("underflow%0d", k), 32'(o_un[k]), 32'(un[k]));
    end
  endtask

  task automatic advance_models();
    for (int k = 0; k < 3; k++) begin
      int n = qs(k);
      logic irdy = n < dep[k];
      logic ordy = n != 0 || ((bp[k] != 0) && ie);
      logic push = ie && irdy, pop = oe && ordy;
      ov[k] = (ov[k] && !ce) || (ie && !irdy);
      un[k] = (un[k] && !ce) || (oe && !ordy);
      if (fl) begin
        if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
      end else begin
        if (pop && n != 0) begin
          if (k == 0) void'(q0.pop_front()); else if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        end
        if (push && !(pop && n == 0)) begin
          if (k == 0) q0.push_back(din); else if (k == 1) q1.push_back(din); else q2.push_back(din);
        end
      end
    end
  endtask

  task automatic step(input logic i_e, input logic [15:0] d, input logic o_e, input logic f, input logic c);
    ie = i_e; din = d; oe = o_e; fl = f; ce = c;
    #1;
    check_all();
    advance_models();
    @(negedge clk);
  endtask

  task automatic async_reset();
    ie = 0; oe = 0; fl = 0; ce = 0;
    #1;
    reset = 1;
    #1;
    clear_models();
    check_all();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    clear_models();
    @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 33; i++) step(1, 16'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 16'hABCD, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 12; i++) step(1, 16'(i), i % 3 != 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 16'(i + 16'h40), 0, 0, 0);
    async_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'(i + 16'h10), 0, 0, 0);
    step(1, 16'h55, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 2400; i++) begin
      int pp = (i / 150) % 2 ? 30 : 80;
      step($urandom_range(0, 99) < pp, 16'($urandom), $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      if (i % 700 == 699) async_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
